w5300_tx_sched: RTL and testbench

Transaction scheduler between the W5300 bus driver (`w5300_entry`) and its buffer-side data sources. After reset it holds the configuration ROM on the driver's buffer port until the chip reports configuration done. It then shares the driver between two UDP transmit requesters using round-robin arbitration, handshakes `tx_req`/`busy_n`, and reports completion, status and timeouts per requester. It replaces the hand-written INIT/IDLE/BUSY selection logic in the top level.

---
 rtl/w5300_tx_sched.sv | 174 +++++++++++++++++
 tb/tb_w5300_tx_sched.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/w5300_tx_sched.sv
// Transaction scheduler for the W5300 bus driver: holds the config ROM on the
// buffer port until configuration completes, then round-robins two UDP senders.
module w5300_tx_sched #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] ent_buf_addr,
  output logic [DATA_WIDTH-1:0] ent_buf_data,
  output logic                  ent_tx_req,
  input  logic                  ent_busy_n,
  input  logic [2:0]            ent_err_code,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  src0_req,
  output logic [ADDR_WIDTH-1:0] src0_addr,
  input  logic [DATA_WIDTH-1:0] src0_data,
  output logic                  src0_grant,
  output logic                  src0_done,
  input  logic                  src1_req,
  output logic [ADDR_WIDTH-1:0] src1_addr,
  input  logic [DATA_WIDTH-1:0] src1_data,
  output logic                  src1_grant,
  output logic                  src1_done,
  output logic                  done_ok,
  output logic                  timeout_err,
  output logic [2:0]            state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] C_LIMIT = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IDLE = 3'd1,
    S_REQ  = 3'd2,
    S_BUSY = 3'd3,
    S_DONE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SEL_ROM  = 2'd0,
    SEL_SRC0 = 2'd1,
    SEL_SRC1 = 2'd2
  } sel_t;

  state_t          r_state;
  sel_t            r_sel;
  logic            r_last;
  logic [CW-1:0]   r_cnt;
  logic            r_tx_req;
  logic            r_grant0;
  logic            r_grant1;
  logic            r_done0;
  logic            r_done1;
  logic            r_done_ok;
  logic            r_timeout_err;
  logic            w_expired;
  logic            w_pick0;

  assign w_expired = (r_cnt == C_LIMIT);
  // With both requests pending, the source that did not go last wins
  assign w_pick0   = src0_req && (!src1_req || r_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_INIT;
      r_sel         <= SEL_ROM;
      r_last        <= 1'b1;
      r_cnt         <= '0;
      r_tx_req      <= 1'b0;
      r_grant0      <= 1'b0;
      r_grant1      <= 1'b0;
      r_done0       <= 1'b0;
      r_done1       <= 1'b0;
      r_done_ok     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_done_ok <= 1'b0;
      case (r_state)
        S_INIT: begin
          r_sel <= SEL_ROM;
          if (ent_busy_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (w_expired) begin
            r_timeout_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          r_cnt <= '0;
          if (w_pick0) begin
            r_grant0 <= 1'b1;
            r_sel    <= SEL_SRC0;
            r_tx_req <= 1'b1;
            r_state  <= S_REQ;
          end else if (src1_req) begin
            r_grant1 <= 1'b1;
            r_sel    <= SEL_SRC1;
            r_tx_req <= 1'b1;
            r_state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (!ent_busy_n) begin
            r_state  <= S_BUSY;
            r_cnt    <= '0;
            r_tx_req <= 1'b0;
          end else if (w_expired) begin
            r_state       <= S_DONE;
            r_tx_req      <= 1'b0;
            r_timeout_err <= 1'b1;
            r_done0       <= r_grant0;
            r_done1       <= r_grant1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_BUSY: begin
          if (ent_busy_n) begin
            r_state   <= S_DONE;
            r_done0   <= r_grant0;
            r_done1   <= r_grant1;
            r_done_ok <= (ent_err_code == 3'd0);
          end else if (w_expired) begin
            r_state       <= S_DONE;
            r_timeout_err <= 1'b1;
            r_done0       <= r_grant0;
            r_done1       <= r_grant1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_last   <= r_grant1;
          r_grant0 <= 1'b0;
          r_grant1 <= 1'b0;
          r_sel    <= SEL_ROM;
          r_cnt    <= '0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  always_comb begin
    ent_buf_data = rom_data;
    case (r_sel)
      SEL_SRC0: ent_buf_data = src0_data;
      SEL_SRC1: ent_buf_data = src1_data;
      default:  ent_buf_data = rom_data;
    endcase
  end

  assign rom_addr    = ent_buf_addr;
  assign src0_addr   = r_grant0 ? ent_buf_addr : '0;
  assign src1_addr   = r_grant1 ? ent_buf_addr : '0;
  assign ent_tx_req  = r_tx_req;
  assign src0_grant  = r_grant0;
  assign src1_grant  = r_grant1;
  assign src0_done   = r_done0;
  assign src1_done   = r_done1;
  assign done_ok     = r_done_ok;
  assign timeout_err = r_timeout_err;
  assign state       = r_state;

endmodule

// File: tb/tb_w5300_tx_sched.sv
// Scoreboard bench for w5300_tx_sched: directed transactions push expected
// completions, a monitor pops them whenever a done pulse appears.
module tb_w5300_tx_sched;

  logic        clk = 1'b0;
  logic        rst_n, rst_n_t;
  logic [11:0] ent_buf_addr, rom_data, src0_data, src1_data;
  logic        ent_busy_n, src0_req, src1_req;
  logic [2:0]  ent_err_code;

  logic [11:0] ent_buf_data, rom_addr, src0_addr, src1_addr;
  logic        ent_tx_req, src0_grant, src1_grant, src0_done, src1_done, done_ok, timeout_err;
  logic [2:0]  state;

  logic [11:0] t_buf_data, t_rom_addr, t_src0_addr, t_src1_addr;
  logic        t_tx_req, t_src0_grant, t_src1_grant, t_src0_done, t_src1_done, t_done_ok, t_timeout_err;
  logic [2:0]  t_state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit inst;
    bit src;
    bit ok;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  w5300_tx_sched #(.ADDR_WIDTH(12), .DATA_WIDTH(12), .TIMEOUT_CYCLES(100000)) dut (
    .clk(clk), .rst_n(rst_n), .ent_buf_addr(ent_buf_addr), .ent_buf_data(ent_buf_data),
    .ent_tx_req(ent_tx_req), .ent_busy_n(ent_busy_n), .ent_err_code(ent_err_code),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .src0_req(src0_req), .src0_addr(src0_addr), .src0_data(src0_data),
    .src0_grant(src0_grant), .src0_done(src0_done),
    .src1_req(src1_req), .src1_addr(src1_addr), .src1_data(src1_data),
    .src1_grant(src1_grant), .src1_done(src1_done),
    .done_ok(done_ok), .timeout_err(timeout_err), .state(state)
  );

  // Short-watchdog instance, held in reset until the timeout scenario
  w5300_tx_sched #(.ADDR_WIDTH(12), .DATA_WIDTH(12), .TIMEOUT_CYCLES(16)) dut_t (
    .clk(clk), .rst_n(rst_n_t), .ent_buf_addr(ent_buf_addr), .ent_buf_data(t_buf_data),
    .ent_tx_req(t_tx_req), .ent_busy_n(ent_busy_n), .ent_err_code(ent_err_code),
    .rom_addr(t_rom_addr), .rom_data(rom_data),
    .src0_req(src0_req), .src0_addr(t_src0_addr), .src0_data(src0_data),
    .src0_grant(t_src0_grant), .src0_done(t_src0_done),
    .src1_req(src1_req), .src1_addr(t_src1_addr), .src1_data(src1_data),
    .src1_grant(t_src1_grant), .src1_done(t_src1_done),
    .done_ok(t_done_ok), .timeout_err(t_timeout_err), .state(t_state)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkDone(input bit inst, input bit d0, input bit d1, input bit ok);
    exp_t e;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $display("[TB] FAIL unexpected_done: inst %0d got done0=%0b done1=%0b expected none", inst, d0, d1);
    end else begin
      e = sbq.pop_front();
      if (e.inst != inst || d0 == d1 || d1 != e.src || ok != e.ok) begin
        bad++;
        $display("[TB] FAIL done_pulse: got inst=%0d done0=%0b done1=%0b ok=%0b expected inst=%0d src=%0d ok=%0b",
                 inst, d0, d1, ok, e.inst, e.src, e.ok);
      end
    end
  endtask

  // Monitor: every completion pulse is matched against the scoreboard queue
  always @(negedge clk) begin
    if (rst_n && (src0_done || src1_done)) checkDone(1'b0, src0_done, src1_done, done_ok);
    if (rst_n_t && (t_src0_done || t_src1_done)) checkDone(1'b1, t_src0_done, t_src1_done, t_done_ok);
  end

  // Starts at an IDLE negedge with requests already driven; runs one full transaction
  task automatic applyStimulus(input bit src, input int lowCycles, input logic [2:0] err, input bit dropReq);
    exp_t e;
    e.inst = 1'b0;
    e.src  = src;
    e.ok   = (err == 3'd0);
    sbq.push_back(e);
    @(negedge clk);
    checkOutput("req_state", state, 32'd2);
    checkOutput("req_tx_req", ent_tx_req, 32'd1);
    checkOutput("req_grant0", src0_grant, src == 1'b0);
    checkOutput("req_grant1", src1_grant, src == 1'b1);
    checkOutput("req_addr0", src0_addr, (src == 1'b0) ? 32'h123 : 32'h0);
    checkOutput("req_addr1", src1_addr, (src == 1'b1) ? 32'h123 : 32'h0);
    checkOutput("req_buf_data", ent_buf_data, src ? 32'hB02 : 32'hA01);
    if (dropReq) begin
      src0_req = 1'b0;
      src1_req = 1'b0;
    end
    ent_busy_n = 1'b0;
    @(negedge clk);
    checkOutput("busy_state", state, 32'd3);
    checkOutput("busy_tx_req", ent_tx_req, 32'd0);
    repeat (lowCycles - 1) @(negedge clk);
    checkOutput("busy_hold_grant", src1_grant ? 32'd1 : {31'd0, src0_grant} + 32'd0, 32'd1);
    ent_err_code = err;
    ent_busy_n   = 1'b1;
    @(negedge clk);
    checkOutput("done_state", state, 32'd4);
    checkOutput("done_grant_held", src ? src1_grant : src0_grant, 32'd1);
    ent_err_code = 3'd0;
    @(negedge clk);
    checkOutput("idle_state", state, 32'd1);
    checkOutput("idle_grants", {src1_grant, src0_grant}, 32'd0);
    checkOutput("idle_done_low", {src1_done, src0_done, done_ok}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    rst_n = 1'b0; rst_n_t = 1'b0;
    ent_buf_addr = 12'h123; rom_data = 12'h5A5; src0_data = 12'hA01; src1_data = 12'hB02;
    ent_busy_n = 1'b0; ent_err_code = 3'd0; src0_req = 1'b0; src1_req = 1'b0;
    #3;
    checkOutput("rst_state", state, 32'd0);
    checkOutput("rst_outputs", {ent_tx_req, src0_grant, src1_grant, src0_done, src1_done, done_ok, timeout_err}, 32'd0);
    checkOutput("rst_addr0", src0_addr, 32'd0);
    checkOutput("rst_addr1", src1_addr, 32'd0);
    checkOutput("rst_buf_data", ent_buf_data, 32'h5A5);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Configuration wait: 50 cycles with the driver busy
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checkOutput("init_state", state, 32'd0);
      checkOutput("init_buf_data", ent_buf_data, 32'h5A5);
    end
    checkOutput("init_rom_addr", rom_addr, 32'h123);
    ent_busy_n = 1'b1;
    @(negedge clk);
    checkOutput("init_to_idle", state, 32'd1);

    // Single src0 transaction, request dropped after grant
    src0_req = 1'b1;
    applyStimulus(1'b0, 20, 3'd0, 1'b1);

    // src1 alone with a driver error code
    src1_req = 1'b1;
    applyStimulus(1'b1, 3, 3'd2, 1'b1);
    checkOutput("err_no_timeout", timeout_err, 32'd0);

    // Round robin with both requests held
    src0_req = 1'b1; src1_req = 1'b1;
    applyStimulus(1'b0, 2, 3'd0, 1'b0);
    applyStimulus(1'b1, 4, 3'd0, 1'b0);
    applyStimulus(1'b0, 1, 3'd0, 1'b0);
    applyStimulus(1'b1, 2, 3'd0, 1'b1);

    // Reset asserted mid-transaction while BUSY
    src0_req = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_req", state, 32'd2);
    ent_busy_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_busy", state, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_state", state, 32'd0);
    checkOutput("rst_mid_outputs", {ent_tx_req, src0_grant, src1_grant, src0_done, src1_done, done_ok, timeout_err}, 32'd0);
    checkOutput("rst_mid_addr0", src0_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("post_rst_init", {state, src0_grant, ent_tx_req}, 32'd0);
    end
    ent_busy_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_idle", state, 32'd1);
    applyStimulus(1'b0, 3, 3'd0, 1'b1);

    // Watchdog expiry in REQ on the short-timeout instance
    rst_n_t = 1'b1;
    @(negedge clk);
    checkOutput("t_idle", t_state, 32'd1);
    begin
      exp_t e;
      e.inst = 1'b1; e.src = 1'b0; e.ok = 1'b0;
      sbq.push_back(e);
    end
    src0_req = 1'b1;
    @(negedge clk);
    checkOutput("t_req_grant", {t_state, t_src0_grant, t_tx_req}, {29'd0, 3'd2} << 2 | 32'd3);
    checkOutput("t_req_no_err", t_timeout_err, 32'd0);
    src0_req = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checkOutput("t_req_hold", t_state, 32'd2);
    end
    @(negedge clk);
    checkOutput("t_done_state", t_state, 32'd4);
    checkOutput("t_timeout_err", t_timeout_err, 32'd1);
    @(negedge clk);
    checkOutput("t_back_idle", t_state, 32'd1);
    checkOutput("t_err_sticky", t_timeout_err, 32'd1);

    repeat (2) @(negedge clk);
    checkOutput("sb_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
